com_bus_arbiter: RTL and testbench
==================================

# com_bus_arbiter

Round-robin arbiter for the shared common (snoop) bus in the 4-core system. It collects the `Com_Bus_Req_proc` lines from all cache wrappers (4 instruction and 4 data caches). It grants bus ownership to exactly one cache at a time, holds the grant for as long as that cache keeps requesting, and inserts one turnaround cycle before the next grant. It also flags owners that hold the bus longer than a programmed limit.

## Interface
Parameters:
- `NUM_REQ`, 8: number of requesters. Index 0-3 are I-caches 0-3; index 4-7 are D-caches 0-3.
- `ID_W`, 3: width of the grant index. Must equal clog2(`NUM_REQ`).
- `HOLD_W`, 8: width of the tenure counter.
- `MAX_HOLD`, 200: tenure in cycles at which `Bus_Timeout` asserts. Must be at most 2^`HOLD_W`-1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `Com_Bus_Req`, input, `NUM_REQ`: request bit i comes from cache i's `Com_Bus_Req_proc`.
- `Com_Bus_Gnt`, output, `NUM_REQ`: one-hot or zero grant. Bit i drives cache i's `Com_Bus_Gnt_proc`.
- `Gnt_Id`, output, `ID_W`: index of the current owner. Holds the last owner when no grant is active.
- `Bus_Busy`, output, 1: high while any grant is active.
- `Bus_Timeout`, output, 1: high while the current owner's tenure is at or above `MAX_HOLD`.

## Operation
- The FSM has three states: IDLE, GRANT, RELEASE. All outputs are registered.
- Reset values:
  - state = IDLE
  - `Com_Bus_Gnt` = 0
  - `Gnt_Id` = 0
  - `Bus_Busy` = 0
  - `Bus_Timeout` = 0
  - `last_ptr` = `NUM_REQ`-1, so requester 0 has first priority
  - `hold_cnt` = 0
- IDLE:
  - If any `Com_Bus_Req` bit is set, pick the first set bit searching upward from `last_ptr`+1, wrapping modulo `NUM_REQ`.
  - Then set `Com_Bus_Gnt`[w]=1, `Gnt_Id`=w, `last_ptr`=w, `Bus_Busy`=1, `hold_cnt`=0, and go to GRANT.
  - Otherwise stay in IDLE with all outputs unchanged.
- GRANT:
  - While `Com_Bus_Req`[`Gnt_Id`]=1: stay in GRANT and increment `hold_cnt`, saturating at 2^`HOLD_W`-1.
  - `Bus_Timeout` is set on the edge where `hold_cnt` reaches `MAX_HOLD`. It stays set while in GRANT.
  - Timeout never revokes the grant; it is a debug/verification flag only.
  - Requests from other caches are ignored during GRANT; there is no preemption.
  - When `Com_Bus_Req`[`Gnt_Id`]=0 is sampled: clear `Com_Bus_Gnt`, `Bus_Busy`, `Bus_Timeout` and `hold_cnt`, and go to RELEASE.
- RELEASE:
  - Lasts exactly one cycle with no grant (bus turnaround, so tri-stated `Address_Com`/`Data_Bus_Com` drivers settle).
  - Requests are not evaluated. The next state is always IDLE.
- Fairness: any requester that holds its request continuously is granted within `NUM_REQ`-1 foreign tenures.
- A request bit that rises and falls entirely during another cache's tenure is lost. Requesters must hold their request until granted.

## Timing
- Grant latency: a request sampled in IDLE at edge E produces `Com_Bus_Gnt` high after E, visible in the cycle following E.
- Release: owner's request low sampled at edge E1 gives the grant low after E1 (RELEASE). IDLE follows after E1+1, and the earliest next grant is after E1+2. That is a minimum of 2 grant-free cycles between owners.
- Back-to-back by the same requester: it drops its request for at least 1 cycle and re-raises it. It is granted only if no other requester is pending, because `last_ptr` points at it.
- Simultaneous requests in IDLE: exactly one grant goes out, chosen by round-robin order. `Com_Bus_Gnt` never has more than one bit set.
- Reset asserted mid-tenure: on the next edge all outputs return to reset values and the FSM goes to IDLE, regardless of pending requests.
- Invariant: `Bus_Busy` equals the OR-reduction of `Com_Bus_Gnt` every cycle.

## Test plan
- Reset, then `Com_Bus_Req`=8'h00 for 5 cycles: `Com_Bus_Gnt`=0, `Bus_Busy`=0, `Gnt_Id`=0 throughout.
- `Com_Bus_Req`=8'hFF held from reset release; each owner drops its request for 1 cycle after 3 cycles of tenure, then re-raises it:
  - Grant order is 0,1,2,...,7,0.
  - Each tenure is 3 cycles, separated by exactly 2 grant-free cycles.
- Single requester 5 (8'h20) holds its request for 4 cycles:
  - Grant appears 1 cycle after the request.
  - `Gnt_Id`=5, `Com_Bus_Gnt`=8'h20.
  - Grant drops 1 cycle after the request drops.
- `MAX_HOLD`=10 and requester 2 holds its request for 15 cycles:
  - `Bus_Timeout` rises when `hold_cnt`=10 and stays high.
  - Grant is never revoked.
  - `Bus_Timeout` clears with the grant.
- Requester 3 granted; `rst` pulsed for 1 cycle mid-tenure while 8'h48 is pending:
  - Outputs are at reset values the next cycle.
  - After reset the grant goes to requester 3 (lowest index from `last_ptr`=7).
- Requester 1 owns the bus; requester 6 pulses its request for 2 cycles during that tenure only: requester 6 is never granted, and the arbiter returns to IDLE with no grant.

Source files
------------

// File: rtl/com_bus_arbiter.sv
// Round-robin arbiter for the shared snoop bus: one owner at a time, grant held
// while the owner keeps requesting, one turnaround cycle between owners.
module com_bus_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int ID_W     = 3,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] Com_Bus_Req,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt,
  output logic [ID_W-1:0]    Gnt_Id,
  output logic               Bus_Busy,
  output logic               Bus_Timeout,
  output logic [1:0]         dbg_state
);

  // Handshake: a requester raises Com_Bus_Req[i] and holds it until it sees
  // Com_Bus_Gnt[i]; it keeps the bus for as long as the request stays high and
  // gives it back by dropping the request for at least one cycle.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]   LAST_IDX   = ID_W'(NUM_REQ - 1);

  state_t             state;
  logic [ID_W-1:0]    last_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_next;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    cand;

  // Scan downward so the final hit is the nearest set bit after last_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = last_ptr;
    cand       = last_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_ptr) + i) % NUM_REQ);
      if (Com_Bus_Req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign hold_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      Com_Bus_Gnt <= '0;
      Gnt_Id      <= '0;
      Bus_Busy    <= 1'b0;
      Bus_Timeout <= 1'b0;
      last_ptr    <= LAST_IDX;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            Com_Bus_Gnt <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            Gnt_Id      <= pick_id;
            last_ptr    <= pick_id;
            Bus_Busy    <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (Com_Bus_Req[Gnt_Id]) begin
            // Timeout is only a flag; the owner keeps the bus regardless.
            hold_cnt <= hold_next;
            if (hold_next >= MAX_HOLD_C) Bus_Timeout <= 1'b1;
          end else begin
            Com_Bus_Gnt <= '0;
            Bus_Busy    <= 1'b0;
            Bus_Timeout <= 1'b0;
            hold_cnt    <= '0;
            state       <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed bench for com_bus_arbiter: reset, round-robin rotation, single
// requester, tenure timeout, mid-tenure reset and a lost transient request.
module tb_com_bus_arbiter;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               tmo;
  logic [1:0]         st;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_REL = 2'd2;

  com_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .HOLD_W  (8),
    .MAX_HOLD(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Com_Bus_Req(req),
    .Com_Bus_Gnt(gnt),
    .Gnt_Id     (gnt_id),
    .Bus_Busy   (busy),
    .Bus_Timeout(tmo),
    .dbg_state  (st)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NUM_REQ-1:0] e_gnt,
                       input logic [ID_W-1:0] e_id, input logic e_busy,
                       input logic e_tmo, input logic [1:0] e_st);
    n_asserts++;
    assert (gnt === e_gnt) else begin
      n_fail++;
      $error("FAIL %s gnt got=%h exp=%h", tag, gnt, e_gnt);
    end
    n_asserts++;
    assert (gnt_id === e_id) else begin
      n_fail++;
      $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, e_id);
    end
    n_asserts++;
    assert (busy === e_busy) else begin
      n_fail++;
      $error("FAIL %s busy got=%b exp=%b", tag, busy, e_busy);
    end
    n_asserts++;
    assert (tmo === e_tmo) else begin
      n_fail++;
      $error("FAIL %s timeout got=%b exp=%b", tag, tmo, e_tmo);
    end
    n_asserts++;
    assert (st === e_st) else begin
      n_fail++;
      $error("FAIL %s state got=%0d exp=%0d", tag, st, e_st);
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] one_hot;
    logic [ID_W-1:0]    owner;

    // Reset and idle bus.
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0, S_IDLE);
    end

    // All requesting: rotation 0..7,0, 3-cycle tenures, 2 grant-free cycles.
    req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      owner   = ID_W'(n % NUM_REQ);
      one_hot = 8'h01 << owner;
      for (int c = 0; c < 3; c++) begin
        check("rr_tenure", one_hot, owner, 1'b1, 1'b0, S_GRANT);
        if (c < 2) tick();
      end
      if (n == 8) req = 8'h00;
      else        req[owner] = 1'b0;
      tick();
      check("rr_release", 8'h00, owner, 1'b0, 1'b0, S_REL);
      if (n != 8) req[owner] = 1'b1;
      tick();
      check("rr_gap", 8'h00, owner, 1'b0, 1'b0, S_IDLE);
      tick();
    end
    check("rr_idle_end", 8'h00, 3'd0, 1'b0, 1'b0, S_IDLE);

    // Single requester 5.
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("single5_grant", 8'h20, 3'd5, 1'b1, 1'b0, S_GRANT);
    end
    req = 8'h00;
    tick();
    check("single5_drop", 8'h00, 3'd5, 1'b0, 1'b0, S_REL);
    tick();
    check("single5_idle", 8'h00, 3'd5, 1'b0, 1'b0, S_IDLE);

    // Requester 2 holds 15 cycles with MAX_HOLD=10.
    req = 8'h04;
    tick();
    check("tmo_start", 8'h04, 3'd2, 1'b1, 1'b0, S_GRANT);
    for (int k = 1; k < 15; k++) begin
      tick();
      check("tmo_hold", 8'h04, 3'd2, 1'b1, (k >= 10), S_GRANT);
    end
    req = 8'h00;
    tick();
    check("tmo_clear", 8'h00, 3'd2, 1'b0, 1'b0, S_REL);
    tick();

    // Requester 3 owns the bus; reset pulse while 8'h48 is pending.
    req = 8'h08;
    tick();
    check("rst_pre_grant", 8'h08, 3'd3, 1'b1, 1'b0, S_GRANT);
    tick();
    req = 8'h48;
    rst = 1'b1;
    tick();
    check("rst_values", 8'h00, 3'd0, 1'b0, 1'b0, S_IDLE);
    rst = 1'b0;
    tick();
    check("rst_regrant3", 8'h08, 3'd3, 1'b1, 1'b0, S_GRANT);
    req = 8'h00;
    tick();
    check("rst_release", 8'h00, 3'd3, 1'b0, 1'b0, S_REL);
    tick();

    // Requester 1 owns; requester 6 pulses only during that tenure.
    req = 8'h02;
    tick();
    check("lost_own1", 8'h02, 3'd1, 1'b1, 1'b0, S_GRANT);
    req = 8'h42;
    tick();
    check("lost_pulse_a", 8'h02, 3'd1, 1'b1, 1'b0, S_GRANT);
    tick();
    check("lost_pulse_b", 8'h02, 3'd1, 1'b1, 1'b0, S_GRANT);
    req = 8'h02;
    tick();
    check("lost_after", 8'h02, 3'd1, 1'b1, 1'b0, S_GRANT);
    req = 8'h00;
    tick();
    check("lost_release", 8'h00, 3'd1, 1'b0, 1'b0, S_REL);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("lost_no_grant6", 8'h00, 3'd1, 1'b0, 1'b0, S_IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
